axi_lite_cfg_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator.
- Turns one-word commands from a local control source (MIDI/UART parser, test sequencer) into AXI-Lite write or read transactions toward the synth control/status register block.
- Returns BRESP/RRESP and read data on a response handshake.
- One transaction in flight at a time; no bursts, no reordering.

---
 rtl/axi_lite_cfg_master_pkg.sv | 23 ++
 rtl/axi_lite_cfg_master.sv | 183 ++++++++++++++++++
 tb/tb_axi_lite_cfg_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cfg_master_pkg.sv
// Shared definitions for the AXI4-Lite configuration master: response codes,
// FSM state encodings and the synth register-map anchors.
package axi_lite_cfg_master_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [7:0] REG_CARRIER_BASE   = 8'h00;
   localparam logic [7:0] REG_MODULATOR_BASE = 8'h40;
   localparam logic [7:0] REG_ENV_VOLUME     = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

endpackage

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite initiator driven by one-word local commands.
// Define AXI_LITE_CFG_MASTER_TIMEOUT_EN to enable the per-state watchdog abort.
module axi_lite_cfg_master
   import axi_lite_cfg_master_pkg::*;
#(
   parameter int C_DATA_WIDTH     = 32,
   parameter int C_ADDR_WIDTH     = 8,
   parameter int C_TIMEOUT_CYCLES = 255
) (
   input  logic                      m_axi_aclk,
   input  logic                      m_axi_aresetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_timeout,
   output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam logic [C_ADDR_WIDTH-1:0] WORD_MASK = {{(C_ADDR_WIDTH-2){1'b1}}, 2'b00};

   state_t state_reg;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = '1;

`ifdef AXI_LITE_CFG_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);

   state_t        last_state_reg;
   logic [TW-1:0] timer_reg;
   logic [TW-1:0] timer_cur;
   logic          wait_state;
   logic          abort;

   assign wait_state = (state_reg == ST_WR_REQ) || (state_reg == ST_WR_RESP) ||
                       (state_reg == ST_RD_REQ) || (state_reg == ST_RD_RESP);
   // A state change since the previous cycle means this is an entry cycle.
   assign timer_cur  = (state_reg != last_state_reg) ? '0 : timer_reg;
   assign abort      = wait_state && (timer_cur == TW'(C_TIMEOUT_CYCLES - 1));

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         last_state_reg <= ST_IDLE;
         timer_reg      <= '0;
      end else begin
         last_state_reg <= state_reg;
         timer_reg      <= wait_state ? timer_cur + 1'b1 : '0;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^C_TIMEOUT_CYCLES;
   assign rsp_timeout        = 1'b0;
`endif

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_reg     <= ST_IDLE;
         cmd_ready     <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= RESP_OKAY;
`ifdef AXI_LITE_CFG_MASTER_TIMEOUT_EN
         rsp_timeout   <= 1'b0;
`endif
      end else begin
`ifdef AXI_LITE_CFG_MASTER_TIMEOUT_EN
         if (abort) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_resp      <= RESP_SLVERR;
            rsp_timeout   <= 1'b1;
            rsp_rdata     <= '0;
            rsp_valid     <= 1'b1;
            state_reg     <= ST_RSP;
         end else
`endif
         begin
            case (state_reg)
               ST_IDLE: begin
                  if (cmd_valid && cmd_ready) begin
                     cmd_ready <= 1'b0;
`ifdef AXI_LITE_CFG_MASTER_TIMEOUT_EN
                     rsp_timeout <= 1'b0;
`endif
                     if (cmd_write) begin
                        m_axi_awaddr  <= cmd_addr & WORD_MASK;
                        m_axi_wdata   <= cmd_wdata;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state_reg     <= ST_WR_REQ;
                     end else begin
                        m_axi_araddr  <= cmd_addr & WORD_MASK;
                        m_axi_arvalid <= 1'b1;
                        state_reg     <= ST_RD_REQ;
                     end
                  end else begin
                     cmd_ready <= 1'b1;
                  end
               end
               ST_WR_REQ: begin
                  // AW and W retire independently; a dropped valid marks that channel done.
                  if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                  if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                  if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                     m_axi_bready <= 1'b1;
                     state_reg    <= ST_WR_RESP;
                  end
               end
               ST_WR_RESP: begin
                  if (m_axi_bvalid && m_axi_bready) begin
                     rsp_resp     <= m_axi_bresp;
                     rsp_rdata    <= '0;
                     m_axi_bready <= 1'b0;
                     rsp_valid    <= 1'b1;
                     state_reg    <= ST_RSP;
                  end
               end
               ST_RD_REQ: begin
                  if (m_axi_arready) begin
                     m_axi_arvalid <= 1'b0;
                     m_axi_rready  <= 1'b1;
                     state_reg     <= ST_RD_RESP;
                  end
               end
               ST_RD_RESP: begin
                  if (m_axi_rvalid && m_axi_rready) begin
                     rsp_rdata    <= m_axi_rdata;
                     rsp_resp     <= m_axi_rresp;
                     m_axi_rready <= 1'b0;
                     rsp_valid    <= 1'b1;
                     state_reg    <= ST_RSP;
                  end
               end
               ST_RSP: begin
                  if (rsp_ready) begin
                     rsp_valid <= 1'b0;
                     state_reg <= ST_IDLE;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Scoreboard bench for axi_lite_cfg_master with a configurable AXI-Lite slave model.
// Honours AXI_LITE_CFG_MASTER_TIMEOUT_EN for the watchdog scenario.
module tb_axi_lite_cfg_master;
   import axi_lite_cfg_master_pkg::*;

   logic        clk;
   logic        aresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  m_axi_awaddr, m_axi_araddr;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;

   axi_lite_cfg_master #(
      .C_DATA_WIDTH(32), .C_ADDR_WIDTH(8), .C_TIMEOUT_CYCLES(16)
   ) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        timeout;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Slave model configuration and handshake counters
   int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
   logic       ar_never = 1'b0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] rdata_cfg = '0;
   int         aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

   initial begin
      int   aw_cnt, w_cnt, ar_cnt, r_cnt;
      logic aw_seen, w_seen, ar_seen;
      logic p_aw, p_w, p_b, p_ar, p_r;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
      forever begin
         @(negedge clk); #1;
         if (!aresetn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
         end else begin
            if (p_aw) begin aw_seen = 1; aw_hs++; end
            if (p_w)  begin w_seen = 1;  w_hs++;  end
            if (p_b)  begin aw_seen = 0; w_seen = 0; b_hs++; end
            if (p_ar) begin ar_seen = 1; ar_hs++; end
            if (p_r)  begin ar_seen = 0; r_hs++;  end
            if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_delay); w_cnt++; end
            else begin m_axi_wready = 0; w_cnt = 0; end
            m_axi_bvalid = aw_seen && w_seen;
            m_axi_bresp  = bresp_cfg;
            if (m_axi_arvalid) begin m_axi_arready = !ar_never && (ar_cnt >= ar_delay); ar_cnt++; end
            else begin m_axi_arready = 0; ar_cnt = 0; end
            if (ar_seen) begin m_axi_rvalid = (r_cnt >= r_delay); r_cnt++; end
            else begin m_axi_rvalid = 0; r_cnt = 0; end
            m_axi_rdata = rdata_cfg;
            m_axi_rresp = rresp_cfg;
         end
         p_aw = m_axi_awvalid && m_axi_awready;
         p_w  = m_axi_wvalid  && m_axi_wready;
         p_b  = m_axi_bvalid  && m_axi_bready;
         p_ar = m_axi_arvalid && m_axi_arready;
         p_r  = m_axi_rvalid  && m_axi_rready;
      end
   end

   // Response monitor: pops the scoreboard on every rsp handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (aresetn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check_val("rsp_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               $display("rsp: rdata=%08h resp=%0d timeout=%0d", rsp_rdata, rsp_resp, rsp_timeout);
               check_val("rsp_rdata", rsp_rdata, e.rdata);
               check_val("rsp_resp", rsp_resp, e.resp);
               check_val("rsp_timeout", rsp_timeout, e.timeout);
            end
         end
      end
   end

   task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic push, input logic [31:0] er, input logic [1:0] eresp,
                        input logic eto);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      #1;
      while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
      check_val("cmd_accept", cmd_ready, 1);
      if (push) begin
         e.rdata = er; e.resp = eresp; e.timeout = eto;
         exp_q.push_back(e);
      end
      $display("cmd: write=%0d addr=%02h wdata=%08h", w, a, d);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 200) begin @(negedge clk); #1; lat++; end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
      check_val("scoreboard_drain", exp_q.size(), 0);
   endtask

   initial begin
      int lat, cnt, aw0, w0, b0;
      logic saw_rsp;
      aresetn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_cmd_ready", cmd_ready, 0);
      check_val("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
      check_val("rst_readys", {m_axi_bready, m_axi_rready}, 0);
      check_val("rst_regs", {m_axi_awaddr, m_axi_araddr, rsp_resp, rsp_rdata}, 0);
      @(negedge clk); aresetn = 1'b1;
      @(negedge clk); #1;
      check_val("cmd_ready_after_rst", cmd_ready, 1);

      // Write to envelope/volume register, zero-wait slave
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
      issue(1, REG_ENV_VOLUME, 32'h8000_0421, 1, 32'h0, RESP_OKAY, 0);
      #1;
      check_val("wr1_awaddr", m_axi_awaddr, 8'h80);
      check_val("wr1_wdata", m_axi_wdata, 32'h8000_0421);
      check_val("wr1_wstrb", m_axi_wstrb, 4'hF);
      check_val("wr1_prot", {m_axi_awprot, m_axi_arprot}, 0);
      wait_rsp(lat);
      check_val("wr1_latency", lat, 3);
      wait_drain();
      check_val("wr1_aw_beats", aw_hs - aw0, 1);
      check_val("wr1_w_beats", w_hs - w0, 1);
      check_val("wr1_b_beats", b_hs - b0, 1);

      // W completes three cycles ahead of AW; unaligned address bits dropped
      aw_delay = 3; b0 = b_hs;
      issue(1, 8'h06, 32'hA5A5_0004, 1, 32'h0, RESP_OKAY, 0);
      @(negedge clk); #1;
      check_val("wr2_wvalid_dropped", m_axi_wvalid, 0);
      check_val("wr2_awvalid_held", m_axi_awvalid, 1);
      check_val("wr2_awaddr", m_axi_awaddr, 8'h04);
      wait_drain();
      repeat (3) @(negedge clk);
      check_val("wr2_b_beats", b_hs - b0, 1);
      aw_delay = 0;

      // Read with delayed rvalid, response back-pressured
      r_delay = 2; rdata_cfg = 32'h1234_5678; rsp_ready = 1'b0;
      issue(0, REG_MODULATOR_BASE, 32'h0, 1, 32'h1234_5678, RESP_OKAY, 0);
      #1;
      check_val("rd1_araddr", m_axi_araddr, 8'h40);
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check_val("rd1_rsp_hold", {rsp_valid, cmd_ready, rsp_rdata}, {1'b1, 1'b0, 32'h1234_5678});
      end
      @(negedge clk); rsp_ready = 1'b1;
      wait_drain();
      r_delay = 0;

      // Read beyond the map: error response passes through with data
      rresp_cfg = RESP_SLVERR; rdata_cfg = 32'hDEAD_BEEF;
      issue(0, 8'h88, 32'h0, 1, 32'hDEAD_BEEF, RESP_SLVERR, 0);
      #1;
      wait_rsp(lat);
      check_val("rd2_latency", lat, 3);
      wait_drain();
      rresp_cfg = RESP_OKAY;

      // Reset while the write request is pending
      aw_delay = 20; w_delay = 20;
      issue(1, 8'h08, 32'h5555_AAAA, 0, 32'h0, RESP_OKAY, 0);
      #1;
      check_val("rst_mid_awvalid_before", m_axi_awvalid, 1);
      @(negedge clk); aresetn = 1'b0;
      #1;
      check_val("rst_mid_valids", {m_axi_awvalid, m_axi_wvalid}, 0);
      repeat (2) @(negedge clk);
      aresetn = 1'b1; aw_delay = 0; w_delay = 0;
      saw_rsp = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         if (rsp_valid) saw_rsp = 1'b1;
      end
      check_val("rst_mid_no_rsp", saw_rsp, 0);
      issue(1, 8'h0C, 32'h0BAD_F00D, 1, 32'h0, RESP_OKAY, 0);
      wait_drain();

`ifdef AXI_LITE_CFG_MASTER_TIMEOUT_EN
      // Slave never accepts AR: watchdog aborts after 16 cycles
      ar_never = 1'b1;
      issue(0, 8'h10, 32'h0, 1, 32'h0, RESP_SLVERR, 1);
      #1;
      cnt = 0;
      while (m_axi_arvalid && cnt < 100) begin cnt++; @(negedge clk); #1; end
      check_val("to_arvalid_cycles", cnt, 16);
      wait_drain();
      ar_never = 1'b0;
`else
      // Slave never accepts AR: without the watchdog the request waits forever
      ar_never = 1'b1;
      issue(0, 8'h10, 32'h0, 0, 32'h0, RESP_OKAY, 0);
      repeat (1000) @(negedge clk);
      #1;
      check_val("noto_arvalid_held", m_axi_arvalid, 1);
      check_val("noto_no_rsp", rsp_valid, 0);
      @(negedge clk); aresetn = 1'b0; ar_never = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      cnt = 0;
`endif

      issue(0, REG_CARRIER_BASE, 32'h0, 1, 32'hDEAD_BEEF, RESP_OKAY, 0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
